// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 core's K-constant path.
//
// Contents:
//   K_LENGTH_DEFAULT  number of K words in a standard SHA-256 schedule
//   K_WORD_W          width of a single K constant
//   k_seq_state_t     state encoding of the K address sequencer
package sha256_pkg;

  localparam int K_LENGTH_DEFAULT = 64;
  localparam int K_WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } k_seq_state_t;

endpackage

// File: rtl/k_address_sequencer.sv
// K address sequencer: walks the K constant memory from address 0 to
// K_LENGTH-1, issues one read per word, waits out the fixed memory read
// latency and presents each word with its index to the downstream K stage.
// A new word is fetched only after the consumer takes the current one.
//
// Ports:
//   clock                  rising-edge clock
//   reset                  asynchronous, active-high reset
//   enable                 level; high runs the sequence, low aborts to idle
//   k_advance              consumer pulse; current word taken, fetch next
//   k_mem_data             read data from the K memory
//   k_mem_read             one-cycle read strobe to the K memory
//   k_mem_address          read address to the K memory (held between reads)
//   k_valid                k_address/k_data hold a valid word
//   k_address              index of the presented word
//   k_data                 presented K word
//   address_read_complete  all K_LENGTH words delivered and consumed
module k_address_sequencer
  import sha256_pkg::*;
#(
  parameter int  K_LENGTH    = K_LENGTH_DEFAULT,
  parameter int  MEM_LATENCY = 1,
  localparam int AW          = $clog2(K_LENGTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                k_advance,
  input  logic [K_WORD_W-1:0] k_mem_data,
  output logic                k_mem_read,
  output logic [AW-1:0]       k_mem_address,
  output logic                k_valid,
  output logic [AW-1:0]       k_address,
  output logic [K_WORD_W-1:0] k_data,
  output logic                address_read_complete
);

  // MEM_LATENCY is at most 8, so the reload value fits in 3 bits.
  localparam logic [2:0]    CNT_LOAD = 3'(MEM_LATENCY - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(K_LENGTH - 1);

  k_seq_state_t        state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                read_d;
  logic [AW-1:0]       mem_addr_d;
  logic                valid_d;
  logic [AW-1:0]       k_addr_d;
  logic [K_WORD_W-1:0] k_data_d;
  logic                done_d;

  // All outputs are registered so the memory strobe and address cannot
  // glitch from state decoding; the strobe is set on the edge that enters
  // ISSUE, which makes it high exactly for the ISSUE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q               <= IDLE;
      idx_q                 <= '0;
      cnt_q                 <= '0;
      k_mem_read            <= 1'b0;
      k_mem_address         <= '0;
      k_valid               <= 1'b0;
      k_address             <= '0;
      k_data                <= '0;
      address_read_complete <= 1'b0;
    end else begin
      state_q               <= state_d;
      idx_q                 <= idx_d;
      cnt_q                 <= cnt_d;
      k_mem_read            <= read_d;
      k_mem_address         <= mem_addr_d;
      k_valid               <= valid_d;
      k_address             <= k_addr_d;
      k_data                <= k_data_d;
      address_read_complete <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    read_d     = 1'b0;
    mem_addr_d = k_mem_address;
    valid_d    = k_valid;
    k_addr_d   = k_address;
    k_data_d   = k_data;
    done_d     = address_read_complete;

    if (!enable) begin
      // Abort has priority over everything, including a same-cycle
      // k_advance; any read still in flight is simply never captured.
      state_d  = IDLE;
      idx_d    = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      k_addr_d = '0;
      k_data_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = ISSUE;
          read_d     = 1'b1;
          mem_addr_d = idx_q;
        end
        ISSUE: begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
        WAIT: begin
          // Counter hits 0 in the cycle the memory data is valid.
          if (cnt_q == '0) begin
            state_d  = HOLD;
            valid_d  = 1'b1;
            k_addr_d = idx_q;
            k_data_d = k_mem_data;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        HOLD: begin
          if (k_advance) begin
            valid_d = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = ISSUE;
              idx_d      = idx_q + AW'(1);
              read_d     = 1'b1;
              mem_addr_d = idx_q + AW'(1);
            end
          end
        end
        DONE: begin
          // Terminal until enable falls; k_advance is ignored here.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k_address_sequencer.sv
// Directed bench for k_address_sequencer. Two instances share a clock:
// index 0 runs with MEM_LATENCY=1, index 1 with MEM_LATENCY=3. Each has a
// behavioural K ROM holding the SHA-256 constants behind a read pipeline of
// the matching depth.
module tb_k_address_sequencer;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en    [2];
  logic        adv   [2];
  logic [31:0] mdata [2];
  logic        rd    [2];
  logic [5:0]  maddr [2];
  logic        vld   [2];
  logic [5:0]  kaddr [2];
  logic [31:0] kdata [2];
  logic        done  [2];

  int cyc = 0;
  int rdc [2] = '{0, 0};
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] p1;
  logic [31:0] p3 [3];

  always #5 clk = ~clk;

  k_address_sequencer #(.K_LENGTH(64), .MEM_LATENCY(1)) dut_l1 (
    .clock(clk), .reset(rst), .enable(en[0]), .k_advance(adv[0]),
    .k_mem_data(mdata[0]), .k_mem_read(rd[0]), .k_mem_address(maddr[0]),
    .k_valid(vld[0]), .k_address(kaddr[0]), .k_data(kdata[0]),
    .address_read_complete(done[0])
  );

  k_address_sequencer #(.K_LENGTH(64), .MEM_LATENCY(3)) dut_l3 (
    .clock(clk), .reset(rst), .enable(en[1]), .k_advance(adv[1]),
    .k_mem_data(mdata[1]), .k_mem_read(rd[1]), .k_mem_address(maddr[1]),
    .k_valid(vld[1]), .k_address(kaddr[1]), .k_data(kdata[1]),
    .address_read_complete(done[1])
  );

  // ROM models: data appears MEM_LATENCY cycles after the strobe is sampled,
  // and reads zero when no read was issued so a mistimed capture shows up.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    p1    <= rd[0] ? K_ROM[maddr[0]] : 32'h0;
    p3[0] <= rd[1] ? K_ROM[maddr[1]] : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (rd[0]) rdc[0] <= rdc[0] + 1;
    if (rd[1]) rdc[1] <= rdc[1] + 1;
  end

  assign mdata[0] = p1;
  assign mdata[1] = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the first falling edge where k_valid is high; k_advance is
  // dropped at every edge so any pulse set by the caller lasts one cycle.
  task automatic wait_valid(input int d, output int c);
    c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      adv[d] = 1'b0;
      if (vld[d]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk($sformatf("timeout_valid_%0d", d), 32'd0, 32'd1);
  endtask

  task automatic wait_read(input int d, output int c);
    c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      adv[d] = 1'b0;
      if (rd[d]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk($sformatf("timeout_read_%0d", d), 32'd0, 32'd1);
  endtask

  initial begin
    int ci, cv, prev, r0;
    en[0] = 1'b0; en[1] = 1'b0; adv[0] = 1'b0; adv[1] = 1'b0;
    p1 = '0; p3[0] = '0; p3[1] = '0; p3[2] = '0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(vld[0]), 32'd0);
    chk("rst_read", 32'(rd[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_data", kdata[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_read", 32'(rd[0]), 32'd0);

    // Full 64-word walk, latency 1, advance on every valid
    en[0] = 1'b1;
    wait_read(0, ci);
    chk("first_issue_addr", 32'(maddr[0]), 32'd0);
    for (int i = 0; i < 64; i++) begin
      wait_valid(0, cv);
      if (i == 0) chk("first_latency", 32'(cv - ci), 32'd2);
      chk($sformatf("walk_addr_%0d", i), 32'(kaddr[0]), 32'(i));
      chk($sformatf("walk_data_%0d", i), kdata[0], K_ROM[i]);
      chk($sformatf("walk_done_early_%0d", i), 32'(done[0]), 32'd0);
      adv[0] = 1'b1;
    end
    @(negedge clk);
    adv[0] = 1'b0;
    chk("complete_after_last", 32'(done[0]), 32'd1);
    chk("valid_after_last", 32'(vld[0]), 32'd0);
    chk("reads_per_walk", 32'(rdc[0]), 32'd64);

    // DONE: held high 10 cycles with stray k_advance pulses
    for (int i = 0; i < 10; i++) begin
      adv[0] = (i % 3 == 0);
      @(negedge clk);
      chk($sformatf("done_hold_%0d", i), 32'(done[0]), 32'd1);
      chk($sformatf("done_valid_%0d", i), 32'(vld[0]), 32'd0);
    end
    adv[0] = 1'b0;
    chk("done_no_reads", 32'(rdc[0]), 32'd64);
    en[0] = 1'b0;
    @(negedge clk);
    chk("done_cleared", 32'(done[0]), 32'd0);

    // Asynchronous reset while holding word 5
    en[0] = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      wait_valid(0, cv);
      if (i < 5) adv[0] = 1'b1;
    end
    chk("hold5_addr", 32'(kaddr[0]), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(vld[0]), 32'd0);
    chk("async_addr", 32'(kaddr[0]), 32'd0);
    chk("async_data", kdata[0], 32'd0);
    chk("async_maddr", 32'(maddr[0]), 32'd0);
    chk("async_read", 32'(rd[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_read(0, ci);
    chk("post_rst_addr", 32'(maddr[0]), 32'd0);

    // Abort at word 20 with simultaneous k_advance
    for (int i = 0; i <= 20; i++) begin
      wait_valid(0, cv);
      chk($sformatf("run2_addr_%0d", i), 32'(kaddr[0]), 32'(i));
      if (i < 20) adv[0] = 1'b1;
    end
    r0 = rdc[0];
    en[0] = 1'b0;
    adv[0] = 1'b1;
    @(negedge clk);
    adv[0] = 1'b0;
    chk("abort_valid", 32'(vld[0]), 32'd0);
    chk("abort_done", 32'(done[0]), 32'd0);
    chk("abort_read", 32'(rd[0]), 32'd0);
    chk("abort_no_read", 32'(rdc[0] - r0), 32'd0);
    en[0] = 1'b1;
    wait_valid(0, cv);
    chk("restart_addr", 32'(kaddr[0]), 32'd0);
    chk("restart_data", kdata[0], 32'h428a2f98);
    en[0] = 1'b0;

    // Latency 3, advance 4 cycles after valid
    en[1] = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(1, cv);
      chk($sformatf("l3_addr_%0d", i), 32'(kaddr[1]), 32'(i));
      if (i > 0) chk($sformatf("l3_period_%0d", i), 32'(cv - prev), 32'd9);
      prev = cv;
      for (int h = 0; h < 4; h++) begin
        @(negedge clk);
        chk($sformatf("l3_stable_%0d_%0d", i, h), kdata[1], K_ROM[i]);
        chk($sformatf("l3_hold_valid_%0d_%0d", i, h), 32'(vld[1]), 32'd1);
      end
      adv[1] = 1'b1;
    end
    chk("l3_reads", 32'(rdc[1]), 32'd4);

    // k_advance during WAIT must not skip a word or trigger a read
    @(negedge clk);
    adv[1] = 1'b0;
    chk("l3_issue", 32'(rd[1]), 32'd1);
    @(negedge clk);
    adv[1] = 1'b1;
    wait_valid(1, cv);
    chk("wait_adv_addr", 32'(kaddr[1]), 32'd4);
    chk("wait_adv_data", kdata[1], K_ROM[4]);
    chk("wait_adv_reads", 32'(rdc[1]), 32'd5);
    en[1] = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/k_address_sequencer.md
Name: k_address_sequencer

Overview:
- Upstream feeder for the K-constant vector stage of the SHA-256 core.
- Walks the K constant memory from address 0 to K_LENGTH-1 and issues one read per word.
- Tolerates a fixed memory read latency, then presents each word with its address to the downstream K stage.
- Advances only on a per-round request from the compression side; flags address_read_complete after the last word is consumed.

Parameters:
- K_LENGTH, 64, number of K words; address width is $clog2(K_LENGTH).
- MEM_LATENCY, 1, cycles from k_mem_read sampled to k_mem_data valid; legal range 1..8.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; high = run the sequence, low = abort or idle.
- k_advance  in  1  consumer pulse; current word taken, fetch next.
- k_mem_data  in  32  read data from K memory.
- k_mem_read  out  1  one-cycle read strobe to K memory.
- k_mem_address  out  $clog2(K_LENGTH)  read address to K memory.
- k_valid  out  1  k_address/k_data hold a valid word.
- k_address  out  $clog2(K_LENGTH)  index of presented word.
- k_data  out  32  presented K word.
- address_read_complete  out  1  all K_LENGTH words delivered and consumed.

Behaviour:
- Reset is asynchronous: all outputs go to 0, the index goes to 0, and the state goes to IDLE.
- States and transitions:
  - IDLE: outputs idle. Go to ISSUE when enable=1.
  - ISSUE, one cycle: k_mem_read=1, k_mem_address=idx. Load the latency counter with MEM_LATENCY-1. Go to WAIT.
  - WAIT: decrement the counter. When the counter reaches 0, capture k_mem_data into k_data and idx into k_address, set k_valid=1, and go to HOLD.
  - HOLD: keep k_valid=1 and hold k_data/k_address stable.
    - On k_advance with idx==K_LENGTH-1: clear k_valid, set address_read_complete=1, go to DONE.
    - On k_advance otherwise: clear k_valid, idx<=idx+1, go to ISSUE.
  - DONE: address_read_complete stays 1 and k_valid stays 0. k_advance is ignored.
- Latency: if ISSUE is in cycle t, k_valid rises in cycle t+MEM_LATENCY+1.
- Throughput: per-word period is MEM_LATENCY+2 cycles minimum, with k_advance asserted in the first HOLD cycle.
- k_advance outside HOLD has no effect and is not queued.
- enable low in any state returns to IDLE on the next edge. This clears k_valid, address_read_complete, k_mem_read, and idx.
  - An in-flight read is discarded.
  - enable low and k_advance in the same cycle: enable wins.
- Re-entry: enable low then high restarts from address 0. There is no auto-restart from DONE while enable stays high.
- k_mem_address holds its last value outside ISSUE. It is don't-care when k_mem_read=0, but must not glitch.
- idx never exceeds K_LENGTH-1, so no wrap-around occurs. k_address equals idx while k_valid is high.
- k_data is updated only in the capture cycle. It keeps its last value after HOLD and is cleared only by reset or abort.

Decomposition:
- Shared package sha256_pkg holds:
  - K_LENGTH_DEFAULT=64.
  - the state enum (IDLE, ISSUE, WAIT, HOLD, DONE).
  - the K word width constant (32).
- Sub-module: none required. The latency counter is inline.
- A behavioural k_rom model (64x32, SHA-256 constants, MEM_LATENCY pipeline) is a bench-only component.

Test Plan:
- Reset mid-HOLD at word 5 -> all outputs 0 asynchronously, before the next edge. After release with enable=1, the first k_mem_address is 0.
- K_LENGTH=64, MEM_LATENCY=1, enable high, k_advance pulsed on every k_valid:
  - first word is k_address=0, k_data=32'h428a2f98, k_valid rising 2 cycles after ISSUE.
  - second word is address 1, 32'h71374491.
  - last word is address 63, 32'hc67178f2.
  - address_read_complete=1 one cycle after the 64th k_advance.
- MEM_LATENCY=3, k_advance delayed 4 cycles -> k_data stays stable throughout HOLD, per-word period is 9 cycles, and exactly one k_mem_read pulse per word.
- k_advance pulsed during WAIT and during DONE -> no index change and no extra reads; address_read_complete stays 1 in DONE.
- enable dropped at word 20 in the same cycle as k_advance -> IDLE next cycle with k_valid=0. Re-asserting enable restarts at address 0 with data 32'h428a2f98.
- enable held high after DONE for 10 cycles -> no further k_mem_read pulses; address_read_complete stays 1 until enable falls, then 0 the next cycle.
